// File: rtl/simplebus_pkg.sv
// Shared constants and state encoding for the simplebus host.
package simplebus_pkg;

    localparam logic [7:0] BUS_IDLE      = 8'h00;
    localparam logic [7:0] CMD_READ      = 8'h02;
    localparam logic [7:0] CMD_WRITE     = 8'h03;
    localparam logic [7:0] CMD_READ_ACK  = 8'h82;
    localparam logic [7:0] CMD_WRITE_ACK = 8'h83;

    localparam int unsigned ADDR_BYTES = 4;
    localparam int unsigned DATA_BYTES = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TX_CMD,
        ST_TX_ADDR,
        ST_TX_SEL,
        ST_TX_DATA,
        ST_WAIT_RSP,
        ST_RX_DATA,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/simplebus_beat.sv
// Bus beat generator: phase bit / bus clock, tx/rx strobes and the registered
// output byte with its odd parity.
module simplebus_beat
    import simplebus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_byte_i,
    output logic       tx_strobe_o,
    output logic       rx_strobe_o,
    output logic       bus_clk_o,
    output logic [7:0] bus_o,
    output logic       bus_pty_o
);

    logic       ph_q;
    logic [7:0] bus_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q  <= 1'b0;
            bus_q <= BUS_IDLE;
        end else begin
            ph_q <= ~ph_q;
            // ph high now means this edge takes it 1->0: the bus update edge
            if (ph_q) begin
                bus_q <= tx_byte_i;
            end
        end
    end

    assign tx_strobe_o = ph_q;
    assign rx_strobe_o = ~ph_q;
    assign bus_clk_o   = ph_q;
    assign bus_o       = bus_q;
    assign bus_pty_o   = ~^bus_q;

endmodule

// File: rtl/simplebus_host.sv
// Wishbone-to-simplebus master. Optional input parity checking is enabled by
// defining SIMPLEBUS_PARITY_CHECK_EN.
module simplebus_host
    import simplebus_pkg::*;
#(
    parameter int unsigned TIMEOUT_BEATS = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [28:0] wb_adr_i,
    input  logic [63:0] wb_dat_i,
    input  logic [7:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [63:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    output logic        ext_bus_clk,
    output logic [7:0]  ext_bus_out,
    output logic        ext_bus_pty_out,
    input  logic [7:0]  ext_bus_in,
    input  logic        ext_bus_pty_in,
    output logic        err_o
);

    localparam int unsigned CW = ($clog2(TIMEOUT_BEATS + 1) > 8) ? $clog2(TIMEOUT_BEATS + 1) : 8;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_BEATS - 1);

    state_e        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   adr_q, adr_d;
    logic [63:0]   wdat_q, wdat_d;
    logic [63:0]   rdat_q, rdat_d;
    logic [7:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [7:0]    tx_byte;
    logic          tx_stb, rx_stb;
    logic          rx_bad;

`ifdef SIMPLEBUS_PARITY_CHECK_EN
    assign rx_bad = (ext_bus_pty_in != ~^ext_bus_in);
`else
    logic unused_pty;
    assign unused_pty = ext_bus_pty_in;
    assign rx_bad     = 1'b0;
`endif

    simplebus_beat u_beat (
        .clk         (clk),
        .rst         (rst),
        .tx_byte_i   (tx_byte),
        .tx_strobe_o (tx_stb),
        .rx_strobe_o (rx_stb),
        .bus_clk_o   (ext_bus_clk),
        .bus_o       (ext_bus_out),
        .bus_pty_o   (ext_bus_pty_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    // Each TX state presents its byte on a tx strobe and advances in the same cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        err_d   = err_q;
        tx_byte = BUS_IDLE;
        unique case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d   = {wb_adr_i, 3'b000};
                    wdat_d  = wb_dat_i;
                    sel_d   = wb_sel_i;
                    we_d    = wb_we_i;
                    state_d = ST_TX_CMD;
                end
            end
            ST_TX_CMD: begin
                if (tx_stb) begin
                    tx_byte = we_q ? CMD_WRITE : CMD_READ;
                    idx_d   = '0;
                    state_d = ST_TX_ADDR;
                end
            end
            ST_TX_ADDR: begin
                if (tx_stb) begin
                    tx_byte = adr_q[7:0];
                    adr_d   = adr_q >> 8;
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == 4'(ADDR_BYTES - 1)) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = we_q ? ST_TX_SEL : ST_WAIT_RSP;
                    end
                end
            end
            ST_TX_SEL: begin
                if (tx_stb) begin
                    tx_byte = sel_q;
                    idx_d   = '0;
                    state_d = ST_TX_DATA;
                end
            end
            ST_TX_DATA: begin
                if (tx_stb) begin
                    tx_byte = wdat_q[7:0];
                    wdat_d  = wdat_q >> 8;
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == 4'(DATA_BYTES - 1)) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_WAIT_RSP;
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (rx_stb) begin
                    if (rx_bad) begin
                        state_d = ST_ERR;
                    end else if (ext_bus_in == BUS_IDLE) begin
                        if (cnt_q >= TO_LAST) begin
                            state_d = ST_ERR;
                        end else if (cnt_q != '1) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (ext_bus_in == (we_q ? CMD_WRITE_ACK : CMD_READ_ACK)) begin
                        idx_d   = '0;
                        state_d = we_q ? ST_DONE : ST_RX_DATA;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_RX_DATA: begin
                if (rx_stb) begin
                    if (rx_bad) begin
                        state_d = ST_ERR;
                    end else begin
                        rdat_d = {ext_bus_in, rdat_q[63:8]};
                        idx_d  = idx_q + 4'd1;
                        if (idx_q == 4'(DATA_BYTES - 1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_ERR) begin
            err_d = 1'b1;
        end
    end

    assign wb_ack_o   = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign wb_dat_o   = (state_q == ST_ERR) ? '1 : rdat_q;
    assign wb_stall_o = (state_q != ST_IDLE);
    assign err_o      = err_q;

endmodule
